// File: rtl/collatz_sched_pkg.sv
// Shared types and default widths for the collatz request scheduler.
package collatz_sched_pkg;

    localparam int unsigned DATA_W        = 32;
    localparam int unsigned CNT_W_DEF     = 16;
    localparam int unsigned MAX_COUNT_DEF = (1 << CNT_W_DEF) - 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        RESP   = 2'd3
    } state_e;

endpackage

// File: rtl/collatz.sv
// Collatz iterator: loads n on go, then steps one trajectory term per cycle.
module collatz (
    input  logic        clk,
    input  logic        go,
    input  logic [31:0] n,
    output logic [31:0] dout,
    output logic        done
);

    always_ff @(posedge clk) begin
        if (go) begin
            dout <= n;
        end else if (dout[0]) begin
            dout <= (dout << 1) + dout + 32'd1;
        end else begin
            dout <= dout >> 1;
        end
    end

    assign done = (dout == 32'd1);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, cyclically.
module rr_arbiter #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] idx
);

    localparam int unsigned ID_W = $clog2(NREQ);

    always_comb begin
        logic        found;
        int unsigned j;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            j = (32'(ptr) + off) % NREQ;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/collatz_sched.sv
// Round-robin scheduler sharing one collatz iterator among NREQ requesters;
// returns the trajectory term count per job over a valid/ready response port.
module collatz_sched
    import collatz_sched_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned CNT_W     = CNT_W_DEF,
    parameter int unsigned MAX_COUNT = (1 << CNT_W) - 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DATA_W-1:0]   start,
    output logic [NREQ-1:0]          ack,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [$clog2(NREQ)-1:0]  resp_id,
    output logic [CNT_W-1:0]         resp_count,
    output logic                     resp_err,
    output logic                     busy
);

    localparam int unsigned ID_W = $clog2(NREQ);

    state_e             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [DATA_W-1:0]  n_q, n_d;
    logic               n_zero_q, n_zero_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [NREQ-1:0]    ack_d;
    logic               resp_valid_d;
    logic [ID_W-1:0]    resp_id_d;
    logic [CNT_W-1:0]   resp_count_d;
    logic               resp_err_d;
    logic               busy_d;

    logic [NREQ-1:0]    grant;
    logic [ID_W-1:0]    grant_idx;
    logic [DATA_W-1:0]  start_sel;
    logic               cgo;
    logic               cdone;
    logic [DATA_W-1:0]  cdout_unused;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (req),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (grant_idx)
    );

    collatz u_iter (
        .clk  (clk),
        .go   (cgo),
        .n    (n_q),
        .dout (cdout_unused),
        .done (cdone)
    );

    assign start_sel = start[32'(grant_idx) * DATA_W +: DATA_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            id_q       <= '0;
            n_q        <= '0;
            n_zero_q   <= 1'b0;
            cnt_q      <= '0;
            ack        <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_count <= '0;
            resp_err   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            id_q       <= id_d;
            n_q        <= n_d;
            n_zero_q   <= n_zero_d;
            cnt_q      <= cnt_d;
            ack        <= ack_d;
            resp_valid <= resp_valid_d;
            resp_id    <= resp_id_d;
            resp_count <= resp_count_d;
            resp_err   <= resp_err_d;
            busy       <= busy_d;
        end
    end

    // A zero start value still passes through LAUNCH (without cgo) so that
    // its response never shares a cycle with its ack.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        id_d         = id_q;
        n_d          = n_q;
        n_zero_d     = n_zero_q;
        cnt_d        = cnt_q;
        ack_d        = '0;
        resp_valid_d = resp_valid;
        resp_id_d    = resp_id;
        resp_count_d = resp_count;
        resp_err_d   = resp_err;
        cgo          = 1'b0;

        case (state_q)
            IDLE: begin
                if (|grant) begin
                    id_d     = grant_idx;
                    n_d      = start_sel;
                    n_zero_d = (start_sel == '0);
                    ack_d    = grant;
                    ptr_d    = (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                    state_d  = LAUNCH;
                end
            end
            LAUNCH: begin
                if (n_zero_q) begin
                    resp_valid_d = 1'b1;
                    resp_id_d    = id_q;
                    resp_count_d = '0;
                    resp_err_d   = 1'b1;
                    state_d      = RESP;
                end else begin
                    cgo     = 1'b1;
                    cnt_d   = CNT_W'(1);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cdone) begin
                    resp_valid_d = 1'b1;
                    resp_id_d    = id_q;
                    resp_count_d = cnt_q;
                    resp_err_d   = 1'b0;
                    state_d      = RESP;
                end else if (cnt_q == CNT_W'(MAX_COUNT)) begin
                    resp_valid_d = 1'b1;
                    resp_id_d    = id_q;
                    resp_count_d = CNT_W'(MAX_COUNT);
                    resp_err_d   = 1'b1;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_collatz_sched.sv
// Directed plus randomized bench for collatz_sched against a trajectory-counting model.
module tb_collatz_sched;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned ID_W  = 2;
    localparam int unsigned MAXC  = 65535;
    localparam int unsigned MAXC8 = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req;
    logic [NREQ*32-1:0]   start;
    logic [NREQ-1:0]      ack;
    logic                 resp_valid, resp_ready;
    logic [ID_W-1:0]      resp_id;
    logic [CNT_W-1:0]     resp_count;
    logic                 resp_err, busy;

    logic [NREQ-1:0]      req8;
    logic [NREQ*32-1:0]   start8;
    logic [NREQ-1:0]      ack8;
    logic                 resp_valid8, resp_ready8;
    logic [ID_W-1:0]      resp_id8;
    logic [CNT_W-1:0]     resp_count8;
    logic                 resp_err8, busy8;

    collatz_sched #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .req(req), .start(start), .ack(ack),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_count(resp_count), .resp_err(resp_err), .busy(busy)
    );

    collatz_sched #(.NREQ(NREQ), .CNT_W(CNT_W), .MAX_COUNT(MAXC8)) dut8 (
        .clk(clk), .reset(reset), .req(req8), .start(start8), .ack(ack8),
        .resp_valid(resp_valid8), .resp_ready(resp_ready8), .resp_id(resp_id8),
        .resp_count(resp_count8), .resp_err(resp_err8), .busy(busy8)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    int unsigned cgo_cnt = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (dut.cgo) cgo_cnt <= cgo_cnt + 1;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] bvals [NREQ];
    int          mptr;
    logic [CNT_W-1:0] last_count;
    logic        last_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count trajectory terms from n down to 1, aborting at the term limit.
    function automatic void ref_job(input logic [31:0] n, input int unsigned maxc,
                                    output int unsigned c, output bit e);
        logic [31:0] x;
        x = n;
        if (n == 0) begin
            c = 0; e = 1'b1;
            return;
        end
        c = 1; e = 1'b0;
        while (x != 32'd1) begin
            if (c == maxc) begin
                e = 1'b1;
                return;
            end
            x = x[0] ? x * 32'd3 + 32'd1 : x / 32'd2;
            c++;
        end
    endfunction

    function automatic int next_id(input logic [NREQ-1:0] pend, input int p);
        for (int off = 0; off < int'(NREQ); off++) begin
            int j;
            j = (p + off) % int'(NREQ);
            if (pend[j]) return j;
        end
        return -1;
    endfunction

    // Issue all requesters in mask together and check every grant and response.
    task automatic run_batch(input logic [NREQ-1:0] mask);
        logic [NREQ-1:0] pend;
        int              id, w;
        int unsigned     c, ack_cyc, lat;
        bit              e, quiet;
        pend = mask;
        for (int i = 0; i < int'(NREQ); i++) start[i*32 +: 32] = bvals[i];
        req = mask;
        while (pend != '0) begin
            id = next_id(pend, mptr);
            w = 0;
            do begin step(); w++; end while (ack == '0 && w < 50);
            chk("ack_latency", 64'(w), 64'(1));
            chk("ack_grant", 64'(ack), 64'(1) << id);
            chk("busy_on_grant", 64'(busy), 64'(1));
            if (ack == '0) begin
                req = '0;
                return;
            end
            req[id]  = 1'b0;
            pend[id] = 1'b0;
            mptr     = (id + 1) % int'(NREQ);
            ack_cyc  = cyc;
            ref_job(bvals[id], MAXC, c, e);
            lat = (bvals[id] == 0) ? 1 : 1 + c;
            quiet = 1'b1;
            w = 0;
            do begin
                step(); w++;
                if (ack != '0) quiet = 1'b0;
            end while (!resp_valid && w < 2000);
            chk("resp_latency", 64'(cyc - ack_cyc), 64'(lat));
            chk("resp_id", 64'(resp_id), 64'(id));
            chk("resp_count", 64'(resp_count), 64'(c));
            chk("resp_err", 64'(resp_err), 64'(e));
            chk("no_ack_during_job", 64'(quiet), 64'(1));
            last_count = resp_count;
            last_err   = resp_err;
            step();
            chk("resp_accepted", 64'({busy, resp_valid}), 64'(0));
        end
    endtask

    // Single job on the MAX_COUNT=8 instance.
    task automatic run8(input logic [31:0] n, input int unsigned exp_c, input bit exp_e);
        int unsigned c, a;
        bit          e;
        int          w;
        ref_job(n, MAXC8, c, e);
        start8[31:0] = n;
        req8 = 4'b0001;
        w = 0;
        do begin step(); w++; end while (ack8 == '0 && w < 50);
        chk("lim_ack", 64'({w[7:0], ack8}), 64'({8'd1, 4'b0001}));
        req8 = '0;
        a = cyc;
        w = 0;
        do begin step(); w++; end while (!resp_valid8 && w < 200);
        chk("lim_latency", 64'(cyc - a), 64'(1 + c));
        chk("lim_count", 64'(resp_count8), 64'(exp_c));
        chk("lim_err", 64'(resp_err8), 64'(exp_e));
        step();
        chk("lim_accepted", 64'(resp_valid8), 64'(0));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          w, seen;
        int unsigned c, a, g;
        bit          e;
        logic [63:0] snap;
        logic [NREQ-1:0] m;

        reset = 1'b1; req = '0; start = '0; resp_ready = 1'b1;
        req8 = '0; start8 = '0; resp_ready8 = 1'b1;
        mptr = 0; last_count = '0; last_err = 1'b0;
        repeat (3) step();
        chk("reset_outputs", 64'({ack, resp_valid, resp_id, resp_count, resp_err, busy}), 64'(0));
        chk("reset_outputs8", 64'({ack8, resp_valid8, resp_id8, resp_count8, resp_err8, busy8}), 64'(0));
        chk("reset_no_cgo", 64'(cgo_cnt), 64'(0));
        reset = 1'b0;
        step();

        // All four at once, then 0 and 3 again with the pointer wrapped.
        bvals[0] = 32'd3; bvals[1] = 32'd6; bvals[2] = 32'd7; bvals[3] = 32'd2;
        run_batch(4'b1111);
        bvals[0] = 32'd9; bvals[3] = 32'd1;
        run_batch(4'b1001);

        bvals[0] = 32'd1;
        run_batch(4'b0001);
        chk("n1_count", 64'(last_count), 64'(1));
        chk("n1_err", 64'(last_err), 64'(0));

        g = cgo_cnt;
        bvals[1] = 32'd0;
        run_batch(4'b0010);
        chk("n0_count", 64'(last_count), 64'(0));
        chk("n0_err", 64'(last_err), 64'(1));
        chk("n0_no_cgo", 64'(cgo_cnt), 64'(g));

        bvals[2] = 32'd27;
        run_batch(4'b0100);
        chk("n27_count", 64'(last_count), 64'(112));
        chk("n27_err", 64'(last_err), 64'(0));

        run8(32'd3, 8, 1'b0);
        run8(32'd27, 8, 1'b1);

        // Backpressure with requester 1 waiting, then reset in the middle of its run.
        resp_ready = 1'b0;
        start[31:0] = 32'd5; start[63:32] = 32'd9;
        req = 4'b0001;
        w = 0;
        do begin step(); w++; end while (ack == '0 && w < 50);
        chk("bp_ack0", 64'({w[7:0], ack}), 64'({8'd1, 4'b0001}));
        req = 4'b0010;
        ref_job(32'd5, MAXC, c, e);
        w = 0;
        do begin step(); w++; end while (!resp_valid && w < 200);
        chk("bp_count", 64'(resp_count), 64'(c));
        snap = 64'({1'b1, 2'd0, CNT_W'(c), 1'b0, 4'b0000, 1'b1});
        for (int i = 0; i < 20; i++) begin
            step();
            chk("bp_hold", 64'({resp_valid, resp_id, resp_count, resp_err, ack, busy}), snap);
        end
        resp_ready = 1'b1;
        step();
        chk("bp_release", 64'({resp_valid, ack}), 64'(0));
        step();
        chk("bp_ack1", 64'(ack), 64'(4'b0010));
        req = '0;
        repeat (5) step();
        chk("bp_running", 64'({busy, resp_valid}), 64'(2'b10));
        reset = 1'b1;
        step();
        chk("midrun_reset", 64'({ack, resp_valid, resp_id, resp_count, resp_err, busy}), 64'(0));
        reset = 1'b0;
        mptr = 0;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (resp_valid || busy) seen++;
        end
        chk("aborted_no_resp", 64'(seen), 64'(0));

        for (int r = 0; r < 12; r++) begin
            m = NREQ'($urandom_range(1, 15));
            for (int i = 0; i < int'(NREQ); i++)
                bvals[i] = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 100000));
            run_batch(m);
        end

        a = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
